// File: rtl/iic_pkg.sv
// Shared definitions for the IIC request arbiter: FSM state encoding and
// default sizing constants.
package iic_pkg;

   localparam int N_REQ    = 4;
   localparam int START_TO = 8;
   localparam int RUN_TO   = 4096;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      RUN       = 3'd3,
      DONE      = 3'd4
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches req starting one past
// last_grant and returns the first hit as one-hot plus its index.
module rr_pick
   import iic_pkg::*;
#(
   parameter int N_REQ = iic_pkg::N_REQ,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] winner,
   output logic [IW-1:0]    winner_idx
);

   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      idx        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IW'((int'(last_grant) + 1 + k) % N_REQ);
         if (!found && req[idx]) begin
            found       = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/iic_arbiter.sv
// Arbitrates N_REQ requesters onto one iic_drive instance, sequencing
// launch, busy handshake and completion with start/run timeouts.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | no owner; pick round-robin winner when any req is high
//   LAUNCH    | one-cycle start_en pulse with latched transaction fields
//   WAIT_BUSY | waiting for driver busy to rise (START_TO timeout)
//   RUN       | driver busy; finish on busy fall (RUN_TO timeout)
//   DONE      | one-cycle done/done_err to owner; grant clears after
module iic_arbiter
   import iic_pkg::*;
#(
   parameter int N_REQ    = iic_pkg::N_REQ,
   parameter int START_TO = iic_pkg::START_TO,
   parameter int RUN_TO   = iic_pkg::RUN_TO
)(
   input  logic                 clk_i,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     req_wr_rd,
   input  logic [8*N_REQ-1:0]   req_dev_addr,
   input  logic [16*N_REQ-1:0]  req_register,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     done,
   output logic                 done_err,
   output logic [7:0]           done_rd_data,
   output logic                 start_en,
   output logic                 wr_rd_flag,
   output logic [7:0]           i2c_device_addr,
   output logic [15:0]          register,
   output logic [7:0]           data_byte,
   input  logic                 busy,
   input  logic                 err,
   input  logic [7:0]           rd_data
);

   localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TO_MAX = (RUN_TO > START_TO) ? RUN_TO : START_TO;
   localparam int CW     = $clog2(TO_MAX + 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_TO - 1);
   localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_TO - 1);

   arb_state_t        state, state_nxt;
   logic [CW-1:0]     cnt;
   logic              err_flag;
   logic [IW-1:0]     last_grant;
   logic [N_REQ-1:0]  pick_oh;
   logic [IW-1:0]     pick_idx;
   logic              pick_wr;
   logic [7:0]        pick_addr;
   logic [15:0]       pick_reg;
   logic [7:0]        pick_dat;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_pick (
      .req        (req),
      .last_grant (last_grant),
      .winner     (pick_oh),
      .winner_idx (pick_idx)
   );

   always_comb begin
      pick_wr   = 1'b0;
      pick_addr = '0;
      pick_reg  = '0;
      pick_dat  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) begin
            pick_wr   = req_wr_rd[i];
            pick_addr = req_dev_addr[8*i +: 8];
            pick_reg  = req_register[16*i +: 16];
            pick_dat  = req_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (|req) state_nxt = LAUNCH;
         LAUNCH:    state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (busy)                    state_nxt = RUN;
            else if (cnt == START_LAST)  state_nxt = DONE;
         end
         RUN: begin
            if (!busy)                   state_nxt = DONE;
            else if (cnt == RUN_LAST)    state_nxt = DONE;
         end
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign start_en = (state == LAUNCH);
   assign done     = (state == DONE) ? grant : '0;
   assign done_err = (state == DONE) & err_flag;

   // Timeout counter restarts on every state change and sticks at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst)                     cnt <= '0;
      else if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)          cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         grant           <= '0;
         last_grant      <= IW'(N_REQ - 1);
         err_flag        <= 1'b0;
         wr_rd_flag      <= 1'b0;
         i2c_device_addr <= '0;
         register        <= '0;
         data_byte       <= '0;
         done_rd_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant           <= pick_oh;
                  last_grant      <= pick_idx;
                  wr_rd_flag      <= pick_wr;
                  i2c_device_addr <= pick_addr;
                  register        <= pick_reg;
                  data_byte       <= pick_dat;
               end
            end
            LAUNCH:    err_flag <= 1'b0;
            WAIT_BUSY: if (!busy && cnt == START_LAST) err_flag <= 1'b1;
            RUN: begin
               if (!busy) begin
                  err_flag     <= err;
                  done_rd_data <= rd_data;
               end else if (cnt == RUN_LAST) begin
                  err_flag <= 1'b1;
               end
            end
            DONE:      grant <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iic_arbiter.sv
// Self-checking bench for iic_arbiter: the bench plays iic_drive and the
// requesters, and predicts grants, latches, latencies and status itself.
module tb_iic_arbiter;

   localparam int N  = 4;
   localparam int ST = 8;
   localparam int RT = 64;

   logic            clk_i = 1'b0;
   logic            rst;
   logic [N-1:0]    req, req_wr_rd;
   logic [8*N-1:0]  req_dev_addr, req_data;
   logic [16*N-1:0] req_register;
   logic            busy, err;
   logic [7:0]      rd_data;
   logic [N-1:0]    grant, done;
   logic            done_err, start_en, wr_rd_flag;
   logic [7:0]      done_rd_data, i2c_device_addr, data_byte;
   logic [15:0]     register;

   int vectors = 0;
   int miscompares = 0;
   int next_start = 0;

   logic [N-1:0] obs_grant, obs_done, obs_post_grant, obs_post_done;
   logic         obs_wr, obs_derr, obs_post_start;
   logic [7:0]   obs_addr, obs_dat, obs_rdd, obs_post_rdd;
   logic [15:0]  obs_reg;
   int           obs_lat;
   bit           obs_started, obs_finished, obs_stable, obs_one_shot;

   logic [N-1:0] e_grant;
   logic         e_wr;
   logic [7:0]   e_addr, e_dat;
   logic [15:0]  e_reg;

   iic_arbiter #(.N_REQ(N), .START_TO(ST), .RUN_TO(RT)) dut (
      .clk_i(clk_i), .rst(rst), .req(req), .req_wr_rd(req_wr_rd),
      .req_dev_addr(req_dev_addr), .req_register(req_register), .req_data(req_data),
      .grant(grant), .done(done), .done_err(done_err), .done_rd_data(done_rd_data),
      .start_en(start_en), .wr_rd_flag(wr_rd_flag), .i2c_device_addr(i2c_device_addr),
      .register(register), .data_byte(data_byte),
      .busy(busy), .err(err), .rd_data(rd_data)
   );

   always #5 clk_i = ~clk_i;

   // Round-robin rule: first requesting index at or after next_start, wrapping.
   function automatic int rr_expect(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) if (r[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   function automatic int exp_lat(input int k, input int len);
      if (k == 0) return ST + 1;
      if (len - 1 >= RT) return k + RT + 1;
      return k + len + 1;
   endfunction

   function automatic bit exp_err(input int k, input int len, input bit e);
      if (k == 0) return 1'b1;
      if (len - 1 >= RT) return 1'b1;
      return e;
   endfunction

   task automatic randomize_fields();
      req_wr_rd    = N'($urandom);
      req_dev_addr = {$urandom, $urandom};
      req_register = {$urandom, $urandom};
      req_data     = {$urandom, $urandom};
   endtask

   // Compute the expected latched transaction from the current request inputs.
   task automatic predict(input logic [N-1:0] r);
      int w;
      w       = rr_expect(r, next_start);
      e_grant = (w < 0) ? '0 : N'(1) << w;
      e_wr    = (w < 0) ? 1'b0 : req_wr_rd[w];
      e_addr  = (w < 0) ? 8'h0 : req_dev_addr[8*w +: 8];
      e_reg   = (w < 0) ? 16'h0 : req_register[16*w +: 16];
      e_dat   = (w < 0) ? 8'h0 : req_data[8*w +: 8];
      if (w >= 0) next_start = (w + 1) % N;
   endtask

   // Acts as iic_drive for one transaction: k = cycles after start_en until
   // busy rises (0 = never), len = cycles busy stays high.
   task automatic drive_txn(input int k, input int len, input bit e, input logic [7:0] rd,
                            input bit scramble, input bit keep_req);
      obs_started = 0; obs_finished = 0; obs_stable = 1; obs_one_shot = 1; obs_lat = 0;
      for (int w = 0; w < 20 && !obs_started; w++) begin
         @(negedge clk_i);
         if (start_en === 1'b1) obs_started = 1;
      end
      if (!obs_started) return;
      obs_grant = grant; obs_wr = wr_rd_flag; obs_addr = i2c_device_addr;
      obs_reg = register; obs_dat = data_byte;
      for (int i = 1; i <= RT + ST + 20 && !obs_finished; i++) begin
         @(negedge clk_i);
         if (done !== '0) begin
            obs_finished = 1; obs_lat = i; obs_done = done;
            obs_derr = done_err; obs_rdd = done_rd_data;
         end
         if (start_en !== 1'b0) obs_one_shot = 0;
         if (grant !== obs_grant || wr_rd_flag !== obs_wr || i2c_device_addr !== obs_addr ||
             register !== obs_reg || data_byte !== obs_dat) obs_stable = 0;
         if (k > 0 && i == k) busy = 1'b1;
         if (k > 0 && i == k + len) begin
            busy = 1'b0; err = e; rd_data = rd;
         end else if (k > 0 && i == k + len + 1) begin
            err = 1'b0; rd_data = 8'($urandom);
         end
         if (scramble && !obs_finished) begin
            randomize_fields();
            req = N'($urandom);
         end
      end
      busy = 1'b0; err = 1'b0;
      if (!obs_finished) return;
      @(negedge clk_i);
      obs_post_grant = grant; obs_post_done = done;
      obs_post_rdd = done_rd_data; obs_post_start = start_en;
      if (!keep_req) req = '0;
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk_i);
      rst = 1'b1;
      repeat (cycles) @(negedge clk_i);
      rst = 1'b0;
      next_start = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '1; busy = 1'b0; err = 1'b0; rd_data = 8'h0;
      randomize_fields();
      repeat (3) @(negedge clk_i);
      vectors++;
      if ({grant, done, done_err, start_en, wr_rd_flag} !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: grant=%b done=%b done_err=%b start_en=%b wr_rd=%b required all 0",
                  grant, done, done_err, start_en, wr_rd_flag);
      end
      vectors++;
      if ({i2c_device_addr, register, data_byte, done_rd_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: addr=%h reg=%h data=%h rdd=%h required all 0",
                  i2c_device_addr, register, data_byte, done_rd_data);
      end
      req = '0;
      rst = 1'b0;
      next_start = 0;
      @(negedge clk_i);
      vectors++;
      if (grant !== '0 || start_en !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_no_req: grant=%b start_en=%b required 0", grant, start_en);
      end
   endtask

   task automatic test_single_write();
      randomize_fields();
      req_wr_rd[0] = 1'b0; req_dev_addr[7:0] = 8'h78;
      req_register[15:0] = 16'h3008; req_data[7:0] = 8'h82;
      req = 4'b0001;
      predict(req);
      drive_txn(1, 20, 1'b0, 8'h3C, 1'b0, 1'b0);
      vectors++;
      if (!obs_started || !obs_finished) begin
         miscompares++;
         $display("FAIL write_handshake: started=%0d finished=%0d required 1/1", obs_started, obs_finished);
      end
      vectors++;
      if ({obs_grant, obs_wr, obs_addr, obs_reg, obs_dat} !== {4'b0001, 1'b0, 8'h78, 16'h3008, 8'h82}) begin
         miscompares++;
         $display("FAIL write_fields: grant=%b wr=%b addr=%h reg=%h data=%h required 0001 0 78 3008 82",
                  obs_grant, obs_wr, obs_addr, obs_reg, obs_dat);
      end
      vectors++;
      if (obs_done !== 4'b0001 || obs_derr !== 1'b0 || obs_lat != 22) begin
         miscompares++;
         $display("FAIL write_done: done=%b err=%b lat=%0d required 0001 0 22", obs_done, obs_derr, obs_lat);
      end
      vectors++;
      if (!obs_one_shot || !obs_stable || obs_post_grant !== '0 || obs_post_done !== '0) begin
         miscompares++;
         $display("FAIL write_pulses: one_shot=%0d stable=%0d post_grant=%b post_done=%b required 1 1 0 0",
                  obs_one_shot, obs_stable, obs_post_grant, obs_post_done);
      end
   endtask

   task automatic test_round_robin();
      bit e;
      int k, len;
      apply_reset(2);
      randomize_fields();
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         predict(req);
         e = 1'($urandom); k = $urandom_range(ST, 1); len = $urandom_range(10, 1);
         drive_txn(k, len, e, 8'($urandom), 1'b0, t != 4);
         vectors++;
         if (obs_grant !== (N'(1) << (t % N)) || obs_grant !== e_grant) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: grant=%b required %b", t, obs_grant, N'(1) << (t % N));
         end
         vectors++;
         if ({obs_wr, obs_addr, obs_reg, obs_dat} !== {e_wr, e_addr, e_reg, e_dat}) begin
            miscompares++;
            $display("FAIL rr_fields[%0d]: %b %h %h %h required %b %h %h %h", t,
                     obs_wr, obs_addr, obs_reg, obs_dat, e_wr, e_addr, e_reg, e_dat);
         end
         vectors++;
         if (obs_done !== e_grant || obs_derr !== e || obs_lat != exp_lat(k, len)) begin
            miscompares++;
            $display("FAIL rr_done[%0d]: done=%b err=%b lat=%0d required %b %b %0d", t,
                     obs_done, obs_derr, obs_lat, e_grant, e, exp_lat(k, len));
         end
      end
   endtask

   task automatic test_start_timeout();
      randomize_fields();
      req = N'($urandom_range(15, 1));
      predict(req);
      drive_txn(0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      vectors++;
      if (obs_grant !== e_grant || obs_done !== e_grant) begin
         miscompares++;
         $display("FAIL start_to_owner: grant=%b done=%b required %b", obs_grant, obs_done, e_grant);
      end
      vectors++;
      if (obs_derr !== 1'b1 || obs_lat != ST + 1 || obs_post_grant !== '0) begin
         miscompares++;
         $display("FAIL start_to: err=%b lat=%0d post_grant=%b required 1 %0d 0",
                  obs_derr, obs_lat, obs_post_grant, ST + 1);
      end
   endtask

   task automatic test_read_err();
      int w;
      w = $urandom_range(N - 1, 0);
      randomize_fields();
      req_wr_rd[w] = 1'b1;
      req = N'(1) << w;
      predict(req);
      drive_txn(3, 5, 1'b1, 8'hA5, 1'b0, 1'b0);
      vectors++;
      if (obs_wr !== 1'b1 || obs_grant !== e_grant) begin
         miscompares++;
         $display("FAIL read_dir: wr_rd=%b grant=%b required 1 %b", obs_wr, obs_grant, e_grant);
      end
      vectors++;
      if (obs_rdd !== 8'hA5 || obs_derr !== 1'b1 || obs_done !== e_grant) begin
         miscompares++;
         $display("FAIL read_result: rdd=%h err=%b done=%b required a5 1 %b", obs_rdd, obs_derr, obs_done, e_grant);
      end
      vectors++;
      if (obs_post_rdd !== 8'hA5 || obs_post_done !== '0) begin
         miscompares++;
         $display("FAIL read_hold: rdd=%h done=%b required a5 0", obs_post_rdd, obs_post_done);
      end
   endtask

   // Timeout boundaries: busy rising on the last allowed wait cycle, busy
   // falling on the last allowed run cycle, and busy held one cycle longer.
   task automatic test_boundaries();
      int ks[3];
      int ls[3];
      ks = '{ST, 2, 2};
      ls = '{4, RT, RT + 1};
      for (int t = 0; t < 3; t++) begin
         randomize_fields();
         req = N'($urandom_range(15, 1));
         predict(req);
         drive_txn(ks[t], ls[t], 1'b0, 8'($urandom), 1'b0, 1'b0);
         vectors++;
         if (obs_done !== e_grant || obs_derr !== exp_err(ks[t], ls[t], 1'b0) ||
             obs_lat != exp_lat(ks[t], ls[t])) begin
            miscompares++;
            $display("FAIL boundary[%0d]: done=%b err=%b lat=%0d required %b %b %0d", t, obs_done,
                     obs_derr, obs_lat, e_grant, exp_err(ks[t], ls[t], 1'b0), exp_lat(ks[t], ls[t]));
         end
      end
   endtask

   task automatic test_random();
      bit e;
      int k, len;
      logic [7:0] rd;
      for (int t = 0; t < 16; t++) begin
         randomize_fields();
         req = N'($urandom_range(15, 1));
         predict(req);
         e = 1'($urandom); k = $urandom_range(ST, 1); len = $urandom_range(12, 1); rd = 8'($urandom);
         drive_txn(k, len, e, rd, 1'b1, 1'b0);
         vectors++;
         if ({obs_grant, obs_wr, obs_addr, obs_reg, obs_dat} !== {e_grant, e_wr, e_addr, e_reg, e_dat}) begin
            miscompares++;
            $display("FAIL rand_grant[%0d]: %b %b %h %h %h required %b %b %h %h %h", t, obs_grant,
                     obs_wr, obs_addr, obs_reg, obs_dat, e_grant, e_wr, e_addr, e_reg, e_dat);
         end
         vectors++;
         if (!obs_stable || !obs_one_shot) begin
            miscompares++;
            $display("FAIL rand_stable[%0d]: stable=%0d one_shot=%0d required 1 1", t, obs_stable, obs_one_shot);
         end
         vectors++;
         if (obs_done !== e_grant || obs_derr !== e || obs_rdd !== rd || obs_lat != exp_lat(k, len)) begin
            miscompares++;
            $display("FAIL rand_done[%0d]: done=%b err=%b rdd=%h lat=%0d required %b %b %h %0d", t,
                     obs_done, obs_derr, obs_rdd, obs_lat, e_grant, e, rd, exp_lat(k, len));
         end
         vectors++;
         if (obs_post_grant !== '0 || obs_post_done !== '0 || obs_post_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_post[%0d]: grant=%b done=%b start=%b required 0 0 0", t,
                     obs_post_grant, obs_post_done, obs_post_start);
         end
      end
   endtask

   task automatic test_reset_in_run();
      bit seen;
      bit spurious;
      logic [N-1:0] reqs[2];
      randomize_fields();
      req = 4'b0100;
      predict(req);
      seen = 0;
      for (int w = 0; w < 20 && !seen; w++) begin
         @(negedge clk_i);
         if (start_en === 1'b1) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL rst_run_start: start_en never seen, required within 20 cycles");
      end
      @(negedge clk_i); busy = 1'b1;
      repeat (3) @(negedge clk_i);
      rst = 1'b1;
      @(negedge clk_i);
      vectors++;
      if ({grant, done, done_err, start_en, wr_rd_flag, i2c_device_addr, register, data_byte, done_rd_data} !== '0) begin
         miscompares++;
         $display("FAIL rst_run_clear: grant=%b done=%b err=%b start=%b wr=%b addr=%h reg=%h data=%h rdd=%h required all 0",
                  grant, done, done_err, start_en, wr_rd_flag, i2c_device_addr, register, data_byte, done_rd_data);
      end
      busy = 1'b0; req = '0;
      spurious = 0;
      repeat (2) begin
         @(negedge clk_i);
         if (done !== '0) spurious = 1;
      end
      rst = 1'b0; next_start = 0;
      repeat (3) begin
         @(negedge clk_i);
         if (done !== '0) spurious = 1;
      end
      vectors++;
      if (spurious) begin
         miscompares++;
         $display("FAIL rst_run_nodone: done pulsed after reset, required none");
      end
      reqs = '{4'b1010, 4'b0100};
      for (int t = 0; t < 2; t++) begin
         randomize_fields();
         req = reqs[t];
         predict(req);
         drive_txn(2, 3, 1'b0, 8'h5A, 1'b0, 1'b0);
         vectors++;
         if (obs_grant !== e_grant || obs_done !== e_grant || obs_derr !== 1'b0 || obs_rdd !== 8'h5A) begin
            miscompares++;
            $display("FAIL rst_run_after[%0d]: grant=%b done=%b err=%b rdd=%h required %b %b 0 5a", t,
                     obs_grant, obs_done, obs_derr, obs_rdd, e_grant, e_grant);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_start_timeout();
      test_read_err();
      test_boundaries();
      test_random();
      test_reset_in_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
